// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer writer types and default geometry
package fb_pkg;

    localparam int FB_WIDTH    = 320;
    localparam int FB_HEIGHT   = 180;
    localparam int FB_SIZE     = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_WIDTH  = $clog2(2 * FB_SIZE);
    localparam int COLOR_WIDTH = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        CLEAR = 2'd1,
        FLUSH = 2'd2,
        SWAP  = 2'd3
    } fbw_state_t;

    typedef logic [ADDR_WIDTH-1:0]  fb_addr_t;
    typedef logic [COLOR_WIDTH-1:0] fb_color_t;

    // One queued framebuffer write.
    typedef struct packed {
        fb_addr_t  addr;
        fb_color_t color;
    } pixel_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous show-ahead FIFO for queued pixel writes
//
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   push_i           write push_data_i (ignored when full unless popping too)
//   pop_i            advance read side (ignored when empty)
//   pop_data_o       head entry, valid whenever empty_o is low
//   full_o, empty_o  occupancy flags
module pixel_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DEPTH_C);
    assign pop_data_o = mem_q[rd_ptr_q];

    // A pop frees the slot being written, so push on full is accepted then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - rasterizer pixel stream to double-buffered framebuffer writes
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   px_x, px_y, px_valid     signed pixel stream from the rasterizer (no backpressure)
//   draw_color               colour sampled with px_valid
//   raster_done              pulse: all triangles of the frame rasterized
//   clear_start, clear_color pulse: fill the back buffer with clear_color
//   fb_addr, fb_data, fb_we  registered BRAM write port
//   back_buf                 buffer currently drawn into
//   frame_swap               pulse in the cycle back_buf shows its new value
//   busy                     anything still queued, in flight or not idle
//   overflow                 sticky: a pixel was dropped on a full FIFO
module framebuffer_writer #(
    parameter  int COORD_WIDTH = 32,
    parameter  int FB_WIDTH    = fb_pkg::FB_WIDTH,
    parameter  int FB_HEIGHT   = fb_pkg::FB_HEIGHT,
    parameter  int COLOR_WIDTH = fb_pkg::COLOR_WIDTH,
    parameter  int FIFO_DEPTH  = 16,
    localparam int FB_SIZE     = FB_WIDTH * FB_HEIGHT,
    localparam int ADDR_WIDTH  = $clog2(2 * FB_SIZE)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic signed [COORD_WIDTH-1:0] px_x,
    input  logic signed [COORD_WIDTH-1:0] px_y,
    input  logic                          px_valid,
    input  logic                          raster_done,
    input  logic                          clear_start,
    input  logic        [COLOR_WIDTH-1:0] clear_color,
    input  logic        [COLOR_WIDTH-1:0] draw_color,
    output logic        [ADDR_WIDTH-1:0]  fb_addr,
    output logic        [COLOR_WIDTH-1:0] fb_data,
    output logic                          fb_we,
    output logic                          back_buf,
    output logic                          frame_swap,
    output logic                          busy,
    output logic                          overflow
);

    import fb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0]         FB_WIDTH_A = ADDR_WIDTH'(FB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]         FB_SIZE_A  = ADDR_WIDTH'(FB_SIZE);
    localparam logic [ADDR_WIDTH-1:0]         CLEAR_LAST = ADDR_WIDTH'(FB_SIZE - 1);
    localparam logic signed [COORD_WIDTH-1:0] X_LIM      = COORD_WIDTH'(FB_WIDTH);
    localparam logic signed [COORD_WIDTH-1:0] Y_LIM      = COORD_WIDTH'(FB_HEIGHT);

    // ---------------- S1: bounds check and capture ----------------
    logic                   s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0]  s1_x_q, s1_x_d;
    logic [ADDR_WIDTH-1:0]  s1_y_q, s1_y_d;
    logic [COLOR_WIDTH-1:0] s1_color_q, s1_color_d;
    logic                   in_bounds;

    assign in_bounds = !px_x[COORD_WIDTH-1] && (px_x < X_LIM) &&
                       !px_y[COORD_WIDTH-1] && (px_y < Y_LIM);

    always_comb begin
        s1_valid_d = px_valid && in_bounds;
        // Coordinates are only meaningful when in bounds, so truncation is safe.
        s1_x_d     = ADDR_WIDTH'(px_x);
        s1_y_d     = ADDR_WIDTH'(px_y);
        s1_color_d = draw_color;
    end

    // ---------------- S2: linear address ----------------
    logic                   s2_valid_q, s2_valid_d;
    logic [ADDR_WIDTH-1:0]  s2_addr_q, s2_addr_d;
    logic [COLOR_WIDTH-1:0] s2_color_q, s2_color_d;
    logic [ADDR_WIDTH-1:0]  buf_base;

    assign buf_base = back_buf ? FB_SIZE_A : '0;

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_addr_d  = buf_base + s1_y_q * FB_WIDTH_A + s1_x_q;
        s2_color_d = s1_color_q;
    end

    // ---------------- FIFO and drain path ----------------
    fbw_state_t   state_q, state_d;
    logic         drain_en;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         bypass;
    pixel_entry_t push_entry;
    pixel_entry_t fifo_head;

    assign drain_en = (state_q == RUN) || (state_q == FLUSH);
    assign fifo_pop = drain_en && !fifo_empty;
    // With nothing queued ahead, S2 goes straight to the output register;
    // this keeps px_valid -> fb_we at three cycles without breaking order.
    assign bypass    = drain_en && fifo_empty && s2_valid_q;
    assign fifo_push = s2_valid_q && !bypass;

    always_comb begin
        push_entry       = '0;
        push_entry.addr  = fb_addr_t'(s2_addr_q);
        push_entry.color = fb_color_t'(s2_color_q);
    end

    pixel_fifo #(
        .WIDTH ($bits(pixel_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // ---------------- FSM, clear counter, output register ----------------
    logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
    logic                   pending_q, pending_d;
    logic                   back_buf_q, back_buf_d;
    logic                   frame_swap_q, frame_swap_d;
    logic                   overflow_q, overflow_d;
    logic [ADDR_WIDTH-1:0]  fb_addr_q, fb_addr_d;
    logic [COLOR_WIDTH-1:0] fb_data_q, fb_data_d;
    logic                   fb_we_q, fb_we_d;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        pending_d    = pending_q;
        back_buf_d   = back_buf_q;
        frame_swap_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    if (raster_done) begin
                        pending_d = 1'b1;
                    end
                end else if (raster_done || pending_q) begin
                    state_d = FLUSH;
                end
            end
            CLEAR: begin
                if (raster_done) begin
                    pending_d = 1'b1;
                end
                if (clr_cnt_q == CLEAR_LAST) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                // The final write sits in the output register now and
                // commits on this edge, so the swap cannot overtake it.
                if (!s1_valid_q && !s2_valid_q && fifo_empty) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                back_buf_d   = !back_buf_q;
                frame_swap_d = 1'b1;
                pending_d    = 1'b0;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        fb_we_d    = 1'b0;
        if (state_q == CLEAR) begin
            fb_addr_d = buf_base + clr_cnt_q;
            fb_data_d = clear_color;
            fb_we_d   = 1'b1;
        end else if (fifo_pop) begin
            fb_addr_d = ADDR_WIDTH'(fifo_head.addr);
            fb_data_d = COLOR_WIDTH'(fifo_head.color);
            fb_we_d   = 1'b1;
        end else if (bypass) begin
            fb_addr_d = s2_addr_q;
            fb_data_d = s2_color_q;
            fb_we_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_color_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_addr_q    <= '0;
            s2_color_q   <= '0;
            state_q      <= RUN;
            clr_cnt_q    <= '0;
            pending_q    <= 1'b0;
            back_buf_q   <= 1'b0;
            frame_swap_q <= 1'b0;
            overflow_q   <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_we_q      <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_color_q   <= s1_color_d;
            s2_valid_q   <= s2_valid_d;
            s2_addr_q    <= s2_addr_d;
            s2_color_q   <= s2_color_d;
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            pending_q    <= pending_d;
            back_buf_q   <= back_buf_d;
            frame_swap_q <= frame_swap_d;
            overflow_q   <= overflow_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
        end
    end

    assign back_buf   = back_buf_q;
    assign frame_swap = frame_swap_q;
    assign overflow   = overflow_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign busy       = (state_q != RUN) || !fifo_empty || s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - directed self-checking bench for framebuffer_writer
module tb_framebuffer_writer;

    // 320x8 keeps every full-buffer clear short while keeping the 320-pixel row pitch.
    localparam int FBW = 320;
    localparam int FBH = 8;
    localparam int FBS = FBW * FBH;
    localparam int AW  = $clog2(2 * FBS);
    localparam logic [15:0] CLR = 16'h1234;
    localparam logic [15:0] DRW = 16'hABCD;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic signed [31:0] px_x;
    logic signed [31:0] px_y;
    logic               px_valid;
    logic               raster_done;
    logic               clear_start;
    logic [15:0]        clear_color;
    logic [15:0]        draw_color;
    logic [AW-1:0]      fb_addr;
    logic [15:0]        fb_data;
    logic               fb_we;
    logic               back_buf;
    logic               frame_swap;
    logic               busy;
    logic               overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int bad;
    int seen;

    logic [AW-1:0] addr_q [$];
    logic [15:0]   data_q [$];
    int            cyc_q  [$];

    always #5 clk_in = ~clk_in;

    framebuffer_writer #(
        .COORD_WIDTH (32),
        .FB_WIDTH    (FBW),
        .FB_HEIGHT   (FBH),
        .COLOR_WIDTH (16),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_valid    (px_valid),
        .raster_done (raster_done),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .draw_color  (draw_color),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .back_buf    (back_buf),
        .frame_swap  (frame_swap),
        .busy        (busy),
        .overflow    (overflow)
    );

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (fb_we) begin
            addr_q.push_back(fb_addr);
            data_q.push_back(fb_data);
            cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input int x, input int y);
        px_x     = x;
        px_y     = y;
        px_valid = 1'b1;
        step();
        px_valid = 1'b0;
    endtask

    task automatic clear_log();
        addr_q.delete();
        data_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        rst_in      = 1'b1;
        px_x        = 0;
        px_y        = 0;
        px_valid    = 1'b0;
        raster_done = 1'b0;
        clear_start = 1'b0;
        clear_color = CLR;
        draw_color  = DRW;
        step();
        step();
        rst_in = 1'b0;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_back_buf", back_buf, 0);
        chk("rst_frame_swap", frame_swap, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);

        // Single pixel latency and address
        clear_log();
        send(5, 2);
        draw_color = 16'h0000;
        chk("t1_lat1", fb_we, 0);
        step();
        chk("t1_lat2", fb_we, 0);
        step();
        chk("t1_we", fb_we, 1);
        chk("t1_addr", fb_addr, 645);
        chk("t1_data", fb_data, DRW);
        step();
        chk("t1_we_off", fb_we, 0);
        step();
        chk("t1_count", addr_q.size(), 1);
        draw_color = DRW;

        // Out-of-bounds pixels, then the far in-bounds corner
        clear_log();
        send(-1, 0);
        send(FBW, 0);
        send(0, FBH);
        send(0, -5);
        repeat (5) step();
        chk("t2_oob_count", addr_q.size(), 0);
        chk("t2_overflow", overflow, 0);
        send(FBW - 1, FBH - 1);
        repeat (4) step();
        chk("t2_corner_count", addr_q.size(), 1);
        chk("t2_corner_addr", addr_q[0], FBS - 1);

        // Clear with a pixel arriving mid-clear
        clear_log();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        send(1, 1);
        for (int i = 0; i < FBS + 100 && addr_q.size() < FBS + 1; i++) step();
        repeat (3) step();
        chk("t3_count", addr_q.size(), FBS + 1);
        bad = 0;
        for (int i = 0; i < FBS && i < addr_q.size(); i++) begin
            if (addr_q[i] !== AW'(i) || data_q[i] !== CLR) bad++;
        end
        chk("t3_clear_seq", bad, 0);
        chk("t3_px_addr", addr_q[FBS], 321);
        chk("t3_px_data", data_q[FBS], DRW);
        chk("t3_contiguous", cyc_q[FBS] - cyc_q[0], FBS);
        chk("t3_busy", busy, 0);

        // Flush and swap
        clear_log();
        send(0, 0);
        send(1, 0);
        send(2, 0);
        raster_done = 1'b1;
        step();
        raster_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            step();
            if (frame_swap) seen = 1;
        end
        chk("t4_swap_seen", seen, 1);
        chk("t4_back_buf", back_buf, 1);
        chk("t4_writes_before_swap", addr_q.size(), 3);
        chk("t4_last_addr", addr_q[2], 2);
        step();
        chk("t4_swap_pulse", frame_swap, 0);
        clear_log();
        send(0, 0);
        repeat (4) step();
        chk("t4_new_buf_count", addr_q.size(), 1);
        chk("t4_new_buf_addr", addr_q[0], FBS);

        // Overflow while clearing the second buffer
        clear_log();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 17; i++) send(i, 0);
        step();
        step();
        chk("t5_overflow_set", overflow, 1);
        for (int i = 0; i < FBS + 200 && addr_q.size() < FBS + 16; i++) step();
        repeat (5) step();
        chk("t5_count", addr_q.size(), FBS + 16);
        chk("t5_clear_first", addr_q[0], FBS);
        bad = 0;
        for (int i = 0; i < 16 && FBS + i < addr_q.size(); i++) begin
            if (addr_q[FBS + i] !== AW'(FBS + i) || data_q[FBS + i] !== DRW) bad++;
        end
        chk("t5_order", bad, 0);
        chk("t5_overflow_sticky", overflow, 1);

        // Reset in the middle of a clear
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (1000) step();
        chk("t6_mid_clear_we", fb_we, 1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("t6_rst_we", fb_we, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_back_buf", back_buf, 0);
        chk("t6_rst_overflow", overflow, 0);
        clear_log();
        send(2, 0);
        repeat (4) step();
        chk("t6_px_count", addr_q.size(), 1);
        chk("t6_px_addr", addr_q[0], 2);

        // clear_start and raster_done together: clear first, then swap
        clear_log();
        clear_start = 1'b1;
        raster_done = 1'b1;
        step();
        clear_start = 1'b0;
        raster_done = 1'b0;
        seen = 0;
        for (int i = 0; i < FBS + 100 && seen == 0; i++) begin
            step();
            if (frame_swap) seen = 1;
        end
        chk("t7_swap_seen", seen, 1);
        chk("t7_writes_before_swap", addr_q.size(), FBS);
        chk("t7_last_clear_addr", addr_q[FBS - 1], FBS - 1);
        chk("t7_back_buf", back_buf, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
